rd_drain_arbiter: RTL

Read-domain scheduler that shares one downstream consumer among NUM_SRC async FIFO read ports.
- Drives each FIFO's re from that FIFO's empty flag.
- Merges the read data into one valid/ready stream tagged with the source index.
- Round-robin between sources, optional burst hold.
- Sits in the rclk domain, directly after the read-pointer controllers of the FIFO bank.

---
 rtl/rd_arb_pkg.sv | 17 +
 rtl/rd_arb_rr_pick.sv | 32 +++
 rtl/rd_drain_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the read-domain drain arbiter.
// The burst feature is selected by RD_DRAIN_ARB_BURST_EN in the files that import this package.
package rd_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    localparam int unsigned OBUF_DEPTH  = 2;
    localparam int unsigned BURST_CNT_W = 8;

    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rd_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NUM_SRC.
module rd_arb_rr_pick
    import rd_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               valid,
    output logic [SRC_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!valid && req[cand[SRC_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rd_drain_arbiter.sv
// Shares one valid/ready consumer among NUM_SRC FIFO read ports with round-robin grants.
// Define RD_DRAIN_ARB_BURST_EN to hold a grant for up to BURST_LEN reads; otherwise rotate every read.
module rd_drain_arbiter
    import rd_arb_pkg::*;
#(
    parameter  int unsigned NUM_SRC    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned BURST_LEN  = 4,
    localparam int unsigned SRC_W      = src_w(NUM_SRC)
) (
    input  logic                          rclk,
    input  logic                          r_rstn,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [NUM_SRC-1:0]            fifo_empty,
    output logic [NUM_SRC-1:0]            fifo_re,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] fifo_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          busy
);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("rd_drain_arbiter: NUM_SRC must be 2..16");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("rd_drain_arbiter: BURST_LEN must be 1..255");
    end

    arb_state_e              state, state_n;
    logic [SRC_W-1:0]        grant, grant_n, rr_ptr, rr_ptr_n, grant_inc;
    logic [NUM_SRC-1:0]      elig, re_c;
    logic                    pick_valid;
    logic [SRC_W-1:0]        pick_idx;
    logic                    issue, last_read, room, pop, push, busy_n;
    logic                    inflight;
    logic [SRC_W-1:0]        inflight_src;
    logic [1:0]              occ, credit;
    logic [DATA_WIDTH-1:0]   rdata_arr [NUM_SRC];
    logic [DATA_WIDTH-1:0]   cap_data;
    logic                    h_vld, h_vld_n, t_vld, t_vld_n;
    logic [SRC_W-1:0]        h_src, h_src_n, t_src, t_src_n;
    logic [DATA_WIDTH-1:0]   h_data, h_data_n, t_data, t_data_n;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign rdata_arr[i] = fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign elig      = src_en & ~fifo_empty;
    assign grant_inc = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
    assign cap_data  = rdata_arr[inflight_src];
    assign push      = inflight;
    assign pop       = h_vld & out_ready;
    assign occ       = {1'b0, h_vld} + {1'b0, t_vld};
    assign credit    = 2'(OBUF_DEPTH) - occ - {1'b0, inflight};
    // A head pop in this cycle frees its slot in time for the word issued now.
    assign room      = (credit != 2'd0) || pop;

    rd_arb_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef RD_DRAIN_ARB_BURST_EN
    logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_n;
    assign last_read = (burst_cnt == BURST_CNT_W'(BURST_LEN - 1));
`else
    assign last_read = 1'b1;
`endif

    // Grant FSM: pick in IDLE, read in SERVE until the source drains or the burst ends.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        re_c     = '0;
        issue    = 1'b0;
`ifdef RD_DRAIN_ARB_BURST_EN
        burst_cnt_n = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_n = pick_idx;
                    state_n = SERVE;
`ifdef RD_DRAIN_ARB_BURST_EN
                    burst_cnt_n = '0;
`endif
                end
            end
            SERVE: begin
                if (!elig[grant]) begin
                    state_n  = IDLE;
                    rr_ptr_n = grant_inc;
                end else if (room) begin
                    issue       = 1'b1;
                    re_c[grant] = 1'b1;
`ifdef RD_DRAIN_ARB_BURST_EN
                    burst_cnt_n = burst_cnt + BURST_CNT_W'(1);
`endif
                    if (last_read) begin
                        state_n  = IDLE;
                        rr_ptr_n = grant_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fifo_re = re_c;

    // Two-entry output buffer; head is always the word presented downstream.
    always_comb begin
        h_vld_n  = h_vld;
        h_src_n  = h_src;
        h_data_n = h_data;
        t_vld_n  = t_vld;
        t_src_n  = t_src;
        t_data_n = t_data;
        if (pop) begin
            if (t_vld) begin
                h_vld_n  = 1'b1;
                h_src_n  = t_src;
                h_data_n = t_data;
                t_vld_n  = push;
                t_src_n  = inflight_src;
                t_data_n = cap_data;
            end else begin
                h_vld_n = push;
                if (push) begin
                    h_src_n  = inflight_src;
                    h_data_n = cap_data;
                end
            end
        end else if (push) begin
            if (!h_vld) begin
                h_vld_n  = 1'b1;
                h_src_n  = inflight_src;
                h_data_n = cap_data;
            end else begin
                t_vld_n  = 1'b1;
                t_src_n  = inflight_src;
                t_data_n = cap_data;
            end
        end
        busy_n = (state_n == SERVE) || h_vld_n || issue;
    end

    always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            inflight     <= 1'b0;
            inflight_src <= '0;
            h_vld        <= 1'b0;
            h_src        <= '0;
            h_data       <= '0;
            t_vld        <= 1'b0;
            t_src        <= '0;
            t_data       <= '0;
            busy         <= 1'b0;
`ifdef RD_DRAIN_ARB_BURST_EN
            burst_cnt    <= '0;
`endif
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            rr_ptr       <= rr_ptr_n;
            inflight     <= issue;
            inflight_src <= grant;
            h_vld        <= h_vld_n;
            h_src        <= h_src_n;
            h_data       <= h_data_n;
            t_vld        <= t_vld_n;
            t_src        <= t_src_n;
            t_data       <= t_data_n;
            busy         <= busy_n;
`ifdef RD_DRAIN_ARB_BURST_EN
            burst_cnt    <= burst_cnt_n;
`endif
        end
    end

    assign out_valid = h_vld;
    assign out_data  = h_data;
    assign out_src   = h_src;

endmodule
